// File: rtl/vid_sync_generator_if.sv
// Timing-set bus between the video controller and vid_sync_generator.
// The master offers a complete set with cfg_valid and holds it until cfg_ack.
interface vid_sync_generator_if #(
  parameter int H_WIDTH = 14,
  parameter int V_WIDTH = 13
);
  logic [H_WIDTH-1:0] cfg_h_sync_start;
  logic [H_WIDTH-1:0] cfg_h_sync_end;
  logic [H_WIDTH-1:0] cfg_h_act_start;
  logic [H_WIDTH-1:0] cfg_h_act_end;
  logic [V_WIDTH-1:0] cfg_v_sync_start;
  logic [V_WIDTH-1:0] cfg_v_sync_end;
  logic [V_WIDTH-1:0] cfg_v_act_start;
  logic [V_WIDTH-1:0] cfg_v_act_end;
  logic [V_WIDTH-1:0] cfg_v_last;
  logic               cfg_h_pol;
  logic               cfg_v_pol;
  logic               cfg_valid;
  logic               cfg_ack;

  modport master (
    output cfg_h_sync_start, cfg_h_sync_end, cfg_h_act_start, cfg_h_act_end,
    output cfg_v_sync_start, cfg_v_sync_end, cfg_v_act_start, cfg_v_act_end,
    output cfg_v_last, cfg_h_pol, cfg_v_pol, cfg_valid,
    input  cfg_ack
  );

  modport slave (
    input  cfg_h_sync_start, cfg_h_sync_end, cfg_h_act_start, cfg_h_act_end,
    input  cfg_v_sync_start, cfg_v_sync_end, cfg_v_act_start, cfg_v_act_end,
    input  cfg_v_last, cfg_h_pol, cfg_v_pol, cfg_valid,
    output cfg_ack
  );
endinterface

// File: rtl/vid_sync_generator.sv
// Compares frame-counter position against a double-buffered timing set and
// drives registered syncs, data-enable and start-of-frame/line markers.
module vid_sync_generator #(
  parameter int H_WIDTH = 14,
  parameter int V_WIDTH = 13
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sclr,
  input  logic               enable,
  input  logic               new_line,
  input  logic [H_WIDTH-1:0] h_count,
  input  logic [V_WIDTH-1:0] v_count,
  vid_sync_generator_if.slave cfg,
  output logic               h_sync,
  output logic               v_sync,
  output logic               de,
  output logic               sof,
  output logic               sol,
  output logic               configured
);
  // state | meaning
  // UNCFG | no timing set held; outputs parked low
  // RUN   | shadow set in use, no update offered
  // PEND  | new set offered, waiting for the frame boundary
  typedef enum logic [1:0] {UNCFG, RUN, PEND} state_t;

  typedef struct packed {
    logic [H_WIDTH-1:0] h_sync_start;
    logic [H_WIDTH-1:0] h_sync_end;
    logic [H_WIDTH-1:0] h_act_start;
    logic [H_WIDTH-1:0] h_act_end;
    logic [V_WIDTH-1:0] v_sync_start;
    logic [V_WIDTH-1:0] v_sync_end;
    logic [V_WIDTH-1:0] v_act_start;
    logic [V_WIDTH-1:0] v_act_end;
    logic [V_WIDTH-1:0] v_last;
    logic               h_pol;
    logic               v_pol;
  } timing_t;

  // Half-open [s, e); s > e wraps through zero, s == e is an empty window.
  function automatic logic in_win_h(input logic [H_WIDTH-1:0] c, s, e);
    if (s < e)      return (c >= s) && (c < e);
    else if (s > e) return (c >= s) || (c < e);
    else            return 1'b0;
  endfunction

  function automatic logic in_win_v(input logic [V_WIDTH-1:0] c, s, e);
    if (s < e)      return (c >= s) && (c < e);
    else if (s > e) return (c >= s) || (c < e);
    else            return 1'b0;
  endfunction

  state_t  state_q, state_d;
  timing_t shadow_q, shadow_d;
  timing_t cfg_set;
  logic    cfg_ack_q, cfg_ack_d;
  logic    configured_q, configured_d;
  logic    h_sync_q, h_sync_d;
  logic    v_sync_q, v_sync_d;
  logic    de_q, de_d;
  logic    sof_q, sof_d;
  logic    sol_q, sol_d;
  logic    capture;
  logic    frame_end;
  logic    h_sync_win, v_sync_win, h_act_win, v_act_win;

  assign cfg_set = '{
    h_sync_start: cfg.cfg_h_sync_start,
    h_sync_end:   cfg.cfg_h_sync_end,
    h_act_start:  cfg.cfg_h_act_start,
    h_act_end:    cfg.cfg_h_act_end,
    v_sync_start: cfg.cfg_v_sync_start,
    v_sync_end:   cfg.cfg_v_sync_end,
    v_act_start:  cfg.cfg_v_act_start,
    v_act_end:    cfg.cfg_v_act_end,
    v_last:       cfg.cfg_v_last,
    h_pol:        cfg.cfg_h_pol,
    v_pol:        cfg.cfg_v_pol
  };

  assign frame_end  = enable && new_line && (v_count == shadow_q.v_last);
  assign h_sync_win = in_win_h(h_count, shadow_q.h_sync_start, shadow_q.h_sync_end);
  assign h_act_win  = in_win_h(h_count, shadow_q.h_act_start, shadow_q.h_act_end);
  assign v_sync_win = in_win_v(v_count, shadow_q.v_sync_start, shadow_q.v_sync_end);
  assign v_act_win  = in_win_v(v_count, shadow_q.v_act_start, shadow_q.v_act_end);

  always_comb begin
    state_d      = state_q;
    shadow_d     = shadow_q;
    cfg_ack_d    = 1'b0;
    configured_d = configured_q;
    h_sync_d     = h_sync_q;
    v_sync_d     = v_sync_q;
    de_d         = de_q;
    sof_d        = 1'b0;
    sol_d        = 1'b0;
    capture      = 1'b0;

    // sclr blocks every capture so no ack can escape while cleared.
    case (state_q)
      UNCFG: if (cfg.cfg_valid && !sclr) capture = 1'b1;
      RUN:   if (cfg.cfg_valid && !sclr) state_d = PEND;
      PEND: begin
        if (sclr || !cfg.cfg_valid) state_d = RUN;
        else if (frame_end)         capture = 1'b1;
      end
      default: state_d = UNCFG;
    endcase

    if (capture) begin
      shadow_d     = cfg_set;
      state_d      = RUN;
      cfg_ack_d    = 1'b1;
      configured_d = 1'b1;
    end

    // Outputs always use the shadow as it stood when the sample arrived.
    if (sclr) begin
      h_sync_d = configured_q & ~shadow_q.h_pol;
      v_sync_d = configured_q & ~shadow_q.v_pol;
      de_d     = 1'b0;
    end else if (enable) begin
      if (configured_q) begin
        h_sync_d = h_sync_win ~^ shadow_q.h_pol;
        v_sync_d = v_sync_win ~^ shadow_q.v_pol;
        de_d     = h_act_win && v_act_win;
        sol_d    = (h_count == '0);
        sof_d    = (h_count == '0) && (v_count == '0);
      end else begin
        h_sync_d = 1'b0;
        v_sync_d = 1'b0;
        de_d     = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= UNCFG;
      shadow_q     <= '0;
      cfg_ack_q    <= 1'b0;
      configured_q <= 1'b0;
      h_sync_q     <= 1'b0;
      v_sync_q     <= 1'b0;
      de_q         <= 1'b0;
      sof_q        <= 1'b0;
      sol_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      cfg_ack_q    <= cfg_ack_d;
      configured_q <= configured_d;
      h_sync_q     <= h_sync_d;
      v_sync_q     <= v_sync_d;
      de_q         <= de_d;
      sof_q        <= sof_d;
      sol_q        <= sol_d;
    end
  end

  assign cfg.cfg_ack = cfg_ack_q;
  assign h_sync      = h_sync_q;
  assign v_sync      = v_sync_q;
  assign de          = de_q;
  assign sof         = sof_q;
  assign sol         = sol_q;
  assign configured  = configured_q;
endmodule

// File: tb/tb_vid_sync_generator.sv
// Scoreboard bench for vid_sync_generator: a reference model pushes the
// expected output vector per driven sample, each test pops and compares it.
module tb_vid_sync_generator;
  localparam int HW = 14;
  localparam int VW = 13;

  logic          clk = 1'b0;
  logic          rst;
  logic          sclr;
  logic          enable;
  logic          new_line;
  logic [HW-1:0] h_count;
  logic [VW-1:0] v_count;
  logic          h_sync, v_sync, de, sof, sol, configured;

  vid_sync_generator_if #(.H_WIDTH(HW), .V_WIDTH(VW)) cfg_bus ();

  vid_sync_generator #(.H_WIDTH(HW), .V_WIDTH(VW)) dut (
    .clk        (clk),
    .rst        (rst),
    .sclr       (sclr),
    .enable     (enable),
    .new_line   (new_line),
    .h_count    (h_count),
    .v_count    (v_count),
    .cfg        (cfg_bus),
    .h_sync     (h_sync),
    .v_sync     (v_sync),
    .de         (de),
    .sof        (sof),
    .sol        (sol),
    .configured (configured)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [HW-1:0] hs_s, hs_e, ha_s, ha_e;
    logic [VW-1:0] vs_s, vs_e, va_s, va_e, v_last;
    logic          hpol, vpol;
  } tset_t;

  typedef struct {
    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic          en, nl, clr, valid;
  } stim_t;

  int         checks = 0;
  int         errors = 0;
  logic [6:0] sb_q[$];   // {cfg_ack, configured, h_sync, v_sync, de, sof, sol}

  // reference model state: 0 = unconfigured, 1 = running, 2 = update pending
  int         m_mode;
  logic       m_cfgd, m_hs, m_vs, m_de;
  tset_t      m_sh, offered;

  function automatic tset_t mkset(input int hs, he, vs, ve, input logic hp, vp);
    tset_t t;
    t.hs_s = HW'(hs); t.hs_e = HW'(he);
    t.ha_s = HW'(192); t.ha_e = HW'(2112);
    t.vs_s = VW'(vs); t.vs_e = VW'(ve);
    t.va_s = VW'(41); t.va_e = VW'(1121);
    t.v_last = VW'(1124);
    t.hpol = hp; t.vpol = vp;
    return t;
  endfunction

  function automatic stim_t mk(input int h, v, input logic en, nl, clr, valid);
    stim_t s;
    s.h = HW'(h); s.v = VW'(v); s.en = en; s.nl = nl; s.clr = clr; s.valid = valid;
    return s;
  endfunction

  // Window membership as modular distance from start, compared to window length.
  function automatic logic win_h(input logic [HW-1:0] c, s, e);
    logic [HW-1:0] off, len;
    off = c - s; len = e - s;
    return off < len;
  endfunction

  function automatic logic win_v(input logic [VW-1:0] c, s, e);
    logic [VW-1:0] off, len;
    off = c - s; len = e - s;
    return off < len;
  endfunction

  function automatic logic [6:0] outs();
    return {cfg_bus.cfg_ack, configured, h_sync, v_sync, de, sof, sol};
  endfunction

  task automatic offer(input tset_t t);
    offered = t;
    cfg_bus.cfg_h_sync_start = t.hs_s; cfg_bus.cfg_h_sync_end = t.hs_e;
    cfg_bus.cfg_h_act_start  = t.ha_s; cfg_bus.cfg_h_act_end  = t.ha_e;
    cfg_bus.cfg_v_sync_start = t.vs_s; cfg_bus.cfg_v_sync_end = t.vs_e;
    cfg_bus.cfg_v_act_start  = t.va_s; cfg_bus.cfg_v_act_end  = t.va_e;
    cfg_bus.cfg_v_last = t.v_last;
    cfg_bus.cfg_h_pol = t.hpol; cfg_bus.cfg_v_pol = t.vpol;
  endtask

  task automatic model_reset();
    m_mode = 0; m_cfgd = 1'b0; m_hs = 1'b0; m_vs = 1'b0; m_de = 1'b0; m_sh = '0;
  endtask

  task automatic model_step();
    logic take, sofx, solx, at_end;
    take = 1'b0; sofx = 1'b0; solx = 1'b0;
    at_end = enable && new_line && (v_count == m_sh.v_last);
    if (sclr) begin
      m_hs = m_cfgd ? !m_sh.hpol : 1'b0;
      m_vs = m_cfgd ? !m_sh.vpol : 1'b0;
      m_de = 1'b0;
    end else if (enable && !m_cfgd) begin
      m_hs = 1'b0; m_vs = 1'b0; m_de = 1'b0;
    end else if (enable) begin
      m_hs = win_h(h_count, m_sh.hs_s, m_sh.hs_e) ? m_sh.hpol : !m_sh.hpol;
      m_vs = win_v(v_count, m_sh.vs_s, m_sh.vs_e) ? m_sh.vpol : !m_sh.vpol;
      m_de = win_h(h_count, m_sh.ha_s, m_sh.ha_e) && win_v(v_count, m_sh.va_s, m_sh.va_e);
      solx = (h_count == 0);
      sofx = (h_count == 0) && (v_count == 0);
    end
    if (m_mode == 0) take = cfg_bus.cfg_valid && !sclr;
    else if (m_mode == 1) begin
      if (cfg_bus.cfg_valid && !sclr) m_mode = 2;
    end else begin
      if (sclr || !cfg_bus.cfg_valid) m_mode = 1;
      else take = at_end;
    end
    if (take) begin
      m_sh = offered; m_mode = 1; m_cfgd = 1'b1;
    end
    sb_q.push_back({take, m_cfgd, m_hs, m_vs, m_de, sofx, solx});
  endtask

  task automatic drive(input stim_t s);
    @(negedge clk);
    h_count = s.h; v_count = s.v; enable = s.en; new_line = s.nl;
    sclr = s.clr; cfg_bus.cfg_valid = s.valid;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    stim_t st[$];
    logic [6:0] exp, got;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (outs() !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs got=%b want=0000000", outs());
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    st.push_back(mk(0, 0, 1, 0, 0, 0));
    st.push_back(mk(20, 0, 1, 0, 0, 0));
    st.push_back(mk(200, 50, 1, 0, 0, 0));
    foreach (st[i]) begin
      drive(st[i]);
      exp = sb_q.pop_front(); got = outs();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL uncfg[%0d] got=%b want=%b", i, got, exp);
      end
    end
  endtask

  task automatic test_basic();
    stim_t st[$];
    logic [6:0] exp, got;
    offer(mkset(0, 44, 0, 5, 1'b1, 1'b1));
    st.push_back(mk(0, 0, 1, 0, 0, 1));
    for (int h = 0; h < 46; h++) st.push_back(mk(h, 0, 1, 0, 0, 0));
    for (int h = 190; h < 195; h++) st.push_back(mk(h, 41, 1, 0, 0, 0));
    st.push_back(mk(192, 40, 1, 0, 0, 0));
    st.push_back(mk(192, 4, 1, 0, 0, 0));
    st.push_back(mk(192, 5, 1, 0, 0, 0));
    st.push_back(mk(2111, 1120, 1, 0, 0, 0));
    st.push_back(mk(2112, 1120, 1, 0, 0, 0));
    st.push_back(mk(2111, 1121, 1, 0, 0, 0));
    foreach (st[i]) begin
      drive(st[i]);
      exp = sb_q.pop_front(); got = outs();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL basic[%0d] h=%0d v=%0d got=%b want=%b", i, st[i].h, st[i].v, got, exp);
      end
      if (st[i].h == 192 && st[i].v == 41) begin
        checks++;
        if (de !== 1'b1) begin
          errors++;
          $display("FAIL basic_de_first h=192 v=41 de=%b want=1", de);
        end
      end
    end
  endtask

  task automatic test_pending();
    stim_t st[$];
    logic [6:0] exp, got;
    offer(mkset(2190, 10, 0, 5, 1'b1, 1'b1));
    st.push_back(mk(100, 500, 1, 0, 0, 1));
    st.push_back(mk(2199, 500, 1, 1, 0, 1));
    st.push_back(mk(10, 800, 1, 0, 0, 1));
    st.push_back(mk(2199, 1124, 0, 1, 0, 1));
    st.push_back(mk(2190, 1124, 1, 0, 0, 1));
    st.push_back(mk(2199, 1124, 1, 1, 0, 1));
    foreach (st[i]) begin
      if (i == 0) continue;
    end
    st.push_back(mk(0, 0, 1, 0, 0, 0));
    st.push_back(mk(5, 0, 1, 0, 0, 0));
    st.push_back(mk(9, 0, 1, 0, 0, 0));
    st.push_back(mk(10, 0, 1, 0, 0, 0));
    st.push_back(mk(11, 0, 1, 0, 0, 0));
    st.push_back(mk(2189, 1, 1, 0, 0, 0));
    st.push_back(mk(2190, 1, 1, 0, 0, 0));
    st.push_back(mk(2191, 1, 1, 0, 0, 0));
    st.push_back(mk(16383, 1, 1, 0, 0, 0));
    foreach (st[i]) begin
      drive(st[i]);
      exp = sb_q.pop_front(); got = outs();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL pending[%0d] h=%0d v=%0d got=%b want=%b", i, st[i].h, st[i].v, got, exp);
      end
    end
  endtask

  task automatic test_boundary_same_cycle();
    stim_t st[$];
    logic [6:0] exp, got;
    offer(mkset(100, 100, 0, 5, 1'b1, 1'b1));
    st.push_back(mk(2199, 1124, 1, 1, 0, 1));
    st.push_back(mk(2199, 1124, 1, 1, 0, 1));
    st.push_back(mk(0, 0, 1, 0, 0, 0));
    st.push_back(mk(99, 0, 1, 0, 0, 0));
    st.push_back(mk(100, 0, 1, 0, 0, 0));
    st.push_back(mk(101, 0, 1, 0, 0, 0));
    st.push_back(mk(2195, 0, 1, 0, 0, 0));
    foreach (st[i]) begin
      drive(st[i]);
      exp = sb_q.pop_front(); got = outs();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL same_cycle[%0d] h=%0d v=%0d got=%b want=%b", i, st[i].h, st[i].v, got, exp);
      end
    end
  endtask

  task automatic test_pol_sclr();
    stim_t st[$];
    logic [6:0] exp, got;
    offer(mkset(0, 44, 0, 5, 1'b0, 1'b1));
    st.push_back(mk(50, 300, 1, 0, 0, 1));
    st.push_back(mk(2199, 1124, 1, 1, 0, 1));
    st.push_back(mk(10, 0, 1, 0, 0, 0));
    st.push_back(mk(50, 0, 1, 0, 0, 0));
    st.push_back(mk(10, 0, 1, 0, 0, 0));
    st.push_back(mk(10, 0, 1, 0, 1, 0));
    st.push_back(mk(200, 50, 1, 0, 0, 0));
    st.push_back(mk(200, 50, 1, 0, 1, 0));
    st.push_back(mk(0, 0, 1, 0, 1, 0));
    st.push_back(mk(0, 0, 1, 0, 0, 0));
    foreach (st[i]) begin
      drive(st[i]);
      exp = sb_q.pop_front(); got = outs();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL pol_sclr[%0d] h=%0d v=%0d got=%b want=%b", i, st[i].h, st[i].v, got, exp);
      end
    end
    // sclr while an update is pending drops it back to RUN without an ack
    st.delete();
    offer(mkset(0, 44, 0, 5, 1'b1, 1'b1));
    st.push_back(mk(50, 300, 1, 0, 0, 1));
    st.push_back(mk(2199, 1124, 1, 1, 1, 1));
    st.push_back(mk(2199, 1124, 1, 1, 0, 1));
    st.push_back(mk(2199, 1124, 1, 1, 0, 1));
    st.push_back(mk(10, 0, 1, 0, 0, 0));
    foreach (st[i]) begin
      drive(st[i]);
      exp = sb_q.pop_front(); got = outs();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL sclr_pend[%0d] h=%0d v=%0d got=%b want=%b", i, st[i].h, st[i].v, got, exp);
      end
    end
  endtask

  task automatic test_enable();
    stim_t st[$];
    logic [6:0] exp, got;
    st.push_back(mk(191, 41, 1, 0, 0, 0));
    st.push_back(mk(192, 41, 0, 0, 0, 0));
    st.push_back(mk(193, 41, 1, 0, 0, 0));
    st.push_back(mk(194, 41, 0, 0, 0, 0));
    st.push_back(mk(0, 7, 1, 0, 0, 0));
    st.push_back(mk(0, 7, 0, 0, 0, 0));
    st.push_back(mk(0, 0, 1, 0, 0, 0));
    st.push_back(mk(0, 0, 0, 0, 0, 0));
    st.push_back(mk(1, 0, 1, 0, 0, 0));
    foreach (st[i]) begin
      drive(st[i]);
      exp = sb_q.pop_front(); got = outs();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL enable[%0d] h=%0d v=%0d en=%b got=%b want=%b", i, st[i].h, st[i].v, st[i].en, got, exp);
      end
    end
  endtask

  task automatic test_drop_pend();
    stim_t st[$];
    logic [6:0] exp, got;
    offer(mkset(2190, 10, 0, 5, 1'b1, 1'b1));
    st.push_back(mk(50, 600, 1, 0, 0, 1));
    st.push_back(mk(60, 600, 1, 0, 0, 0));
    st.push_back(mk(2199, 1124, 1, 1, 0, 0));
    st.push_back(mk(5, 0, 1, 0, 0, 0));
    st.push_back(mk(2195, 0, 1, 0, 0, 0));
    foreach (st[i]) begin
      drive(st[i]);
      exp = sb_q.pop_front(); got = outs();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL drop_pend[%0d] h=%0d v=%0d got=%b want=%b", i, st[i].h, st[i].v, got, exp);
      end
    end
  endtask

  task automatic test_rst_mid();
    stim_t st[$];
    logic [6:0] exp, got;
    drive(mk(300, 600, 1, 0, 0, 0));
    exp = sb_q.pop_front(); got = outs();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL rst_mid_pre got=%b want=%b", got, exp);
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (outs() !== 7'b0) begin
      errors++;
      $display("FAIL rst_mid_async got=%b want=0000000", outs());
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    st.push_back(mk(0, 0, 1, 0, 0, 0));
    st.push_back(mk(10, 0, 1, 0, 0, 0));
    foreach (st[i]) begin
      drive(st[i]);
      exp = sb_q.pop_front(); got = outs();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL rst_mid_after[%0d] got=%b want=%b", i, got, exp);
      end
    end
  endtask

  initial begin
    rst = 1'b1; sclr = 1'b0; enable = 1'b0; new_line = 1'b0;
    h_count = '0; v_count = '0;
    cfg_bus.cfg_valid = 1'b0;
    offer('0);
    model_reset();
    test_reset();
    test_basic();
    test_pending();
    test_boundary_same_cycle();
    test_pol_sclr();
    test_enable();
    test_drop_pend();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vid_sync_generator.md
Name: vid_sync_generator

Overview:
- Downstream of the video frame counter in the clocked-video-output path.
- Consumes h_count, v_count and new_line, and compares them against a programmed timing set.
- Produces registered h_sync, v_sync, data-enable and frame/line markers for the output encoder.
- Timing sets are double-buffered: a new set arrives through a valid/ack handshake and takes effect only at a frame boundary.

Parameters:
- H_WIDTH, 14, width of h_count and all horizontal timing values.
- V_WIDTH, 13, width of v_count and all vertical timing values.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- sclr  in  1  synchronous clear
- enable  in  1  counter advance qualifier, same cycle as counts
- new_line  in  1  last sample of line, from the frame counter
- h_count  in  H_WIDTH  horizontal position
- v_count  in  V_WIDTH  vertical position
- cfg_h_sync_start, cfg_h_sync_end  in  H_WIDTH  hsync window
- cfg_h_act_start, cfg_h_act_end  in  H_WIDTH  active horizontal window
- cfg_v_sync_start, cfg_v_sync_end  in  V_WIDTH  vsync window
- cfg_v_act_start, cfg_v_act_end  in  V_WIDTH  active vertical window
- cfg_v_last  in  V_WIDTH  last line index of the frame (total minus one)
- cfg_h_pol, cfg_v_pol  in  1  1 = active-high sync
- cfg_valid  in  1  new timing set offered
- cfg_ack  out  1  one-cycle pulse: set captured into shadow
- h_sync, v_sync  out  1  polarity-applied syncs
- de  out  1  active picture (h_active AND v_active)
- sof  out  1  one-cycle pulse at h_count=0, v_count=0
- sol  out  1  one-cycle pulse at h_count=0 of every line
- configured  out  1  shadow holds a valid set

Behaviour:
- Reset: all outputs 0; shadow cleared; state UNCFG.
- States:
  - UNCFG: cfg_valid=1 captures the set immediately, pulses cfg_ack, goes to RUN.
  - RUN: cfg_valid=1 goes to PEND.
  - PEND: waits for a frame boundary (enable & new_line & v_count==shadow v_last). At the boundary it captures the set, pulses cfg_ack and returns to RUN. If cfg_valid drops first, it returns to RUN with no capture and no ack.
- The cfg_* inputs must stay stable while cfg_valid=1. cfg_ack is registered and asserted in the cycle after capture; the new set applies from the next sample onward.
- cfg_valid rising in the same cycle as a boundary while in RUN is accepted at the next boundary, not this one.
- Windows are half-open, [start, end), using unsigned compare at full width:
  - start < end: active when start <= count < end.
  - start > end: wrap; active when count >= start or count < end.
  - start == end: never active.
- h_sync = h_win XNOR cfg_h_pol; v_sync = v_win XNOR cfg_v_pol (shadowed polarity).
- All outputs are registered with 1-cycle latency from the h_count/v_count sampled with enable=1. When enable=0 the outputs hold their values, except sof/sol, which deassert.
- sof and sol are generated only in RUN or PEND. In UNCFG, sync outputs sit at 0 and de=0.
- sclr:
  - Forces de, sof and sol to 0, and h_sync/v_sync to their inactive level per the shadow polarity (0 if UNCFG).
  - Returns PEND to RUN and suppresses cfg_ack.
  - Keeps shadow contents and configured.
  - Takes priority over enable.
- rst asserted mid-frame: immediate return to the reset state; the shadow is lost.

Test Plan:
- Reset, then cfg_valid with h_sync [0,44), h_act [192,2112), v_sync [0,5), v_act [41,1121), v_last=1124, pols=1 -> cfg_ack one cycle later; configured=1; from counts h=0,v=0: h_sync=1 for h 0..43, de=1 at h=192,v=41 one cycle after the input.
- Offer a new set mid-frame at v=500 -> no ack until enable & new_line at v=1124; cfg_ack the next cycle; the new windows apply from h=0,v=0.
- Wrap window h_sync [2190,10) -> active for h>=2190 and for h 0..9; equal start/end -> h_sync stays at its inactive level all line.
- cfg_h_pol=0 -> h_sync low inside the window; sclr asserted -> h_sync=1, de=0, sof=0 next cycle, shadow retained.
- enable toggling 1-0-1 across h=191..193 -> de holds during the enable=0 cycle; sol/sof are never stretched.
- cfg_valid dropped while in PEND -> no cfg_ack and the old timings continue; rst mid-frame -> all outputs 0 and configured=0 immediately.
